// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, issues one outstanding request at a
// time, and presents a registered IF/ID instruction with decode stall and branch redirect.
module fetch_unit #(
    parameter int unsigned     N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [N-1:0]  redirect_pc,
    output logic          if_valid,
    output logic [N-1:0]  if_pc,
    output logic [31:0]   if_instr,
    output logic [10:0]   if_op
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [N-1:0] PC_STEP    = N'(4);
    localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

    state_t        state_q, state_d;
    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  inflight_pc_q, inflight_pc_d;
    logic [31:0]   hold_instr_q, hold_instr_d;
    logic [N-1:0]  hold_pc_q, hold_pc_d;
    logic          if_valid_q, if_valid_d;
    logic [N-1:0]  if_pc_q, if_pc_d;
    logic [31:0]   if_instr_q, if_instr_d;

    logic [N-1:0]  redirect_tgt;
    logic          out_loadable;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign out_loadable = !if_valid_q || !stall;

    // Gating with reset keeps the request low while reset is held, even though
    // the state register already reads FETCH.
    assign imem_req  = (state_q == FETCH) && reset;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_op     = if_instr_q[31:21];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        if_valid_d    = if_valid_q && stall;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;

        // A redirect flushes the output regardless of stall.
        if (redirect) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            FETCH: begin
                if (imem_gnt) begin
                    inflight_pc_d = pc_q;
                    if (redirect) begin
                        state_d = DROP;
                        pc_d    = redirect_tgt;
                    end else begin
                        state_d = WAIT;
                        pc_d    = pc_q + PC_STEP;
                    end
                end else if (redirect) begin
                    pc_d = redirect_tgt;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    if (out_loadable) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = inflight_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = inflight_pc_q;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (out_loadable) begin
                    if_instr_d = hold_instr_q;
                    if_pc_d    = hold_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                // The outstanding response belongs to a flushed path; swallow it.
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small latency-programmable memory responder plus
// hand-computed expectations; a second instance checks the RESET_PC wrap in lockstep.
module tb_fetch_unit;

    logic         clk;
    logic         reset;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         stall;
    logic         redirect;
    logic [63:0]  redirect_pc;

    logic         imem_req,  imem_req2;
    logic [63:0]  imem_addr, imem_addr2;
    logic         if_valid,  if_valid2;
    logic [63:0]  if_pc,     if_pc2;
    logic [31:0]  if_instr,  if_instr2;
    logic [10:0]  if_op,     if_op2;

    int n_checks;
    int n_fail;

    // responder state
    int          lat;
    bit          pend;
    int          cnt;
    logic [63:0] paddr;
    bit          fire;
    logic [63:0] faddr;

    fetch_unit #(.N(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_op(if_op)
    );

    fetch_unit #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2), .if_op(if_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0)      return 32'hF840_0000;
        else if (a == 64'h4) return 32'hB400_0000;
        else                 return {8'hAA, a[23:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; the responder sees grants at the edge and answers after lat cycles.
    task automatic step();
        @(negedge clk);
        fire  = imem_req && imem_gnt;
        faddr = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (fire) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = faddr;
        end
        if (pend) begin
            if (cnt == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(if_valid), 64'h0);
        check({tag, "_pc"},    if_pc,         64'h0);
        check({tag, "_instr"}, 64'(if_instr), 64'h0);
        check({tag, "_op"},    64'(if_op),    64'h0);
        check({tag, "_req"},   64'(imem_req), 64'h0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        lat         = 1;
        pend        = 1'b0;
        cnt         = 0;
        paddr       = '0;
        reset       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        step();
        step();
        check_zero_outputs("rst");
        check("rst_addr",      imem_addr,  64'h0);
        check("rst_addr_wrap", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);

        // Back-to-back fetch with 1-cycle memory
        reset = 1'b1;
        #1;
        check("c0_req",  64'(imem_req), 64'h1);
        check("c0_addr", imem_addr,     64'h0);
        step();                                             // C1: WAIT, rvalid
        check("c1_valid",     64'(if_valid), 64'h0);
        check("c1_req",       64'(imem_req), 64'h0);
        check("c1_wrap_addr", imem_addr2,    64'h0);
        step();                                             // C2
        check("c2_valid", 64'(if_valid), 64'h1);
        check("c2_pc",    if_pc,         64'h0);
        check("c2_op",    64'(if_op),    64'h7C2);
        check("c2_addr",  imem_addr,     64'h4);
        step();                                             // C3
        check("c3_valid", 64'(if_valid), 64'h0);
        step();                                             // C4
        check("c4_valid", 64'(if_valid), 64'h1);
        check("c4_pc",    if_pc,         64'h4);
        check("c4_op",    64'(if_op),    64'h5A0);
        check("c4_addr",  imem_addr,     64'h8);

        // Stall for 6 cycles; the next response parks in the hold buffer
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();                                         // C5..C10
            check("stall_valid", 64'(if_valid), 64'h1);
            check("stall_pc",    if_pc,         64'h4);
            check("stall_instr", 64'(if_instr), 64'hB400_0000);
            if (i >= 1) check("hold_req", 64'(imem_req), 64'h0);
        end
        stall = 1'b0;
        step();                                             // C11
        check("unhold_valid", 64'(if_valid), 64'h1);
        check("unhold_pc",    if_pc,         64'h8);
        check("unhold_instr", 64'(if_instr), 64'(mem_word(64'h8)));
        check("resume_req",   64'(imem_req), 64'h1);
        check("resume_addr",  imem_addr,     64'hC);
        step();                                             // C12
        step();                                             // C13
        check("c13_pc", if_pc, 64'hC);

        // Redirect while waiting; the late response must be dropped
        lat = 4;
        step();                                             // C14: WAIT
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        step();                                             // C15: DROP
        redirect = 1'b0;
        check("drop_req", 64'(imem_req), 64'h0);
        for (int i = 0; i < 2; i++) begin
            step();                                         // C16, C17
            check("drop_valid", 64'(if_valid), 64'h0);
        end
        check("late_rvalid", 64'(imem_rvalid), 64'h1);
        lat = 1;
        step();                                             // C18
        check("redir_req",   64'(imem_req), 64'h1);
        check("redir_addr",  imem_addr,     64'h100);
        check("redir_valid", 64'(if_valid), 64'h0);
        step();                                             // C19
        check("c19_valid", 64'(if_valid), 64'h0);
        step();                                             // C20
        check("redir_out_valid", 64'(if_valid), 64'h1);
        check("redir_out_pc",    if_pc,         64'h100);

        // Redirect coincident with a grant
        check("c20_addr", imem_addr, 64'h104);
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        step();                                             // C21: DROP, old rvalid
        redirect = 1'b0;
        check("gr_flush_valid", 64'(if_valid), 64'h0);
        check("gr_drop_req",    64'(imem_req), 64'h0);
        step();                                             // C22
        check("gr_req",   64'(imem_req), 64'h1);
        check("gr_addr",  imem_addr,     64'h200);
        check("gr_valid", 64'(if_valid), 64'h0);
        step();                                             // C23
        step();                                             // C24
        check("gr_out_valid", 64'(if_valid), 64'h1);
        check("gr_out_pc",    if_pc,         64'h200);
        check("gr_out_instr", 64'(if_instr), 64'(mem_word(64'h200)));

        // Reset in the middle of a WAIT; the response lands during reset
        lat = 3;
        step();                                             // C25: WAIT
        reset = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        check("mid_rst_addr", imem_addr, 64'h0);
        step();                                             // C26
        step();                                             // C27: stale rvalid
        check("stale_rvalid", 64'(imem_rvalid), 64'h1);
        check_zero_outputs("rst_rv");
        lat = 1;
        step();                                             // C28
        reset = 1'b1;
        #1;
        check("rel_req",  64'(imem_req), 64'h1);
        check("rel_addr", imem_addr,     64'h0);
        step();                                             // C29
        check("rel_valid0", 64'(if_valid), 64'h0);
        step();                                             // C30
        check("rel_valid", 64'(if_valid), 64'h1);
        check("rel_pc",    if_pc,         64'h0);
        check("rel_instr", 64'(if_instr), 64'hF840_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the LEGv8 core; sits directly upstream of the main decoder.
- Owns the PC, issues single-outstanding requests to instruction memory, absorbs variable memory latency, and presents a registered IF/ID instruction.
- Presents the 11-bit opcode field (instr[31:21]) that drives the main decoder.
- Supports decode stall (hold) and branch redirect (flush).

Parameters:
- N, 64, PC/address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req  out  1  fetch request; asserted only in state FETCH.
- imem_addr  out  N  fetch address; equals pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, earliest 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot consume if_* this cycle.
- redirect  in  1  taken branch; flush and refetch.
- redirect_pc  in  N  branch target.
- if_valid  out  1  if_* holds a valid instruction.
- if_pc  out  N  address of if_instr.
- if_instr  out  32  fetched instruction.
- if_op  out  11  if_instr[31:21]; feeds main decoder Op.

Behaviour:
- Reset (async, reset=0):
  - state=FETCH, pc=RESET_PC; inflight_pc, hold buffer cleared.
  - if_valid=0, if_pc=0, if_instr=0, if_op=0.
  - imem_req is 0 while reset=0; it rises combinationally once reset deasserts.
- Registers: pc (next fetch address), inflight_pc, hold_instr/hold_pc (one-entry skid), output regs.
- PC arithmetic:
  - On gnt: inflight_pc<=pc; pc<=pc+4, modulo 2^N; wraps from all-ones-minus-3 to 0.
  - redirect_pc[1:0] is forced to 0 when loaded.
- Consumption: output is consumed when if_valid=1 and stall=0.
  - If consumed with no new load this cycle: if_valid<=0.
  - Output regs load only when if_valid=0 or stall=0.
- States:
  - FETCH: imem_req=1.
    - gnt && !redirect -> WAIT.
    - gnt && redirect -> DROP; pc<=redirect_pc.
    - !gnt && redirect -> FETCH; pc<=redirect_pc.
  - WAIT: waiting for rvalid.
    - rvalid, output loadable -> if_instr<=rdata, if_pc<=inflight_pc, if_valid<=1, go to FETCH.
    - rvalid, output stalled full -> hold<=rdata/inflight_pc, go to HOLD.
    - redirect (with or without rvalid) -> if rvalid in the same cycle, discard it and go to FETCH; else go to DROP. pc<=redirect_pc in both cases.
  - HOLD: no requests.
    - When output loadable, move hold buffer into output regs (if_valid<=1) and go to FETCH.
    - redirect -> discard hold buffer, go to FETCH.
  - DROP: no requests.
    - On rvalid, discard data and go to FETCH.
    - redirect here updates pc and stays in DROP.
- Redirect precedence:
  - Overrides stall and every other event.
  - Clears if_valid the next cycle.
  - Never lets a pre-redirect instruction reach if_*.
- Latency and throughput:
  - gnt@t, rvalid@t+1 -> if_valid@t+2.
  - Peak throughput is 1 instruction per 2 cycles (single outstanding).
- if_op is always if_instr[31:21].
- Reset asserted mid-operation aborts any in-flight request; an rvalid arriving after reset is ignored (state=FETCH does not sample rvalid).

Test Plan:
- Reset, then 1-cycle memory with gnt=1 and rdata per address: {0x0:0xF8400000, 0x4:0xB4000000} -> imem_addr 0x0 then 0x4; if_op=0x7C2 with if_pc=0x0, then if_op=0x5A0 with if_pc=0x4; first if_valid 2 cycles after first gnt.
- stall=1 held for 6 cycles with if_valid=1:
  - if_* unchanged throughout.
  - Next rvalid goes to HOLD; imem_req=0 in HOLD.
  - stall=0 -> held instruction appears next cycle, then fetching resumes at +4.
- redirect=1, redirect_pc=0x103 while in WAIT; rvalid arrives 3 cycles later:
  - Data discarded; if_valid never shows it.
  - Next imem_addr=0x100.
- redirect and gnt in the same FETCH cycle -> DROP; the response for the old pc is discarded; next request address=redirect_pc.
- Reset asserted mid-WAIT, rvalid during reset -> all outputs zero; after release the first request is at RESET_PC and the stale data is never output.
- RESET_PC = 2^64-4 -> second request address 0x0 (wrap).
